line_window_3x3: RTL and testbench

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

---
 rtl/line_window_3x3_if.sv | 23 ++
 rtl/line_window_3x3.sv | 126 ++++++++++++
 tb/tb_line_window_3x3.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_3x3_if.sv
// rtl/line_window_3x3_if.sv - pixel-in / window-out handshake bundle for line_window_3x3
interface line_window_3x3_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [9*DATA_W-1:0]   win_data;

  // Window generator side
  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data
  );

  // Pixel source / window sink side
  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data
  );
endinterface

// File: rtl/line_window_3x3.sv
// rtl/line_window_3x3.sv - 3x3 sliding window over a raster pixel stream; LINE_WINDOW_FRAME_DONE_EN adds frame_done
module line_window_3x3 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  line_window_3x3_if.slave     bus
`ifdef LINE_WINDOW_FRAME_DONE_EN
  ,
  output logic                 frame_done
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              win_valid_q, win_valid_d;
  logic [DATA_W-1:0] win_q   [3][3];
  logic [DATA_W-1:0] line1_q [IMG_W];
  logic [DATA_W-1:0] line2_q [IMG_W];

  logic              accept;
  logic              qualify;
  logic              frame_last;
  logic [DATA_W-1:0] tap1;
  logic [DATA_W-1:0] tap2;

  // A new pixel can enter whenever the output slot is empty or being drained.
  assign bus.in_ready = !win_valid_q || bus.win_ready;
  assign bus.win_valid = win_valid_q;
  assign accept     = bus.in_valid && bus.in_ready;
  assign qualify    = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign tap1       = line1_q[col_q];
  assign tap2       = line2_q[col_q];

  // Raster position and output-valid next state
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    if (accept) begin
      // Only pixels at row>=2, col>=2 close a patch that lies wholly in one frame.
      win_valid_d = qualify;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Position counters, valid flag and the 3x3 shift window
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= tap2;
        win_q[1][2] <= tap1;
        win_q[2][2] <= bus.in_data;
      end
    end
  end

  // Line buffers: row-1 moves down to row-2, the incoming pixel becomes row-1.
  // Contents are not reset; rows 0 and 1 of a frame never produce a window.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      line2_q[col_q] <= tap1;
      line1_q[col_q] <= bus.in_data;
    end
  end

  // Flatten the window, element (r,c) at slot r*3+c
  always_comb begin
    bus.win_data = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus.win_data[(r*3+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

`ifdef LINE_WINDOW_FRAME_DONE_EN
  logic frame_done_q;

  // One-cycle pulse after the last pixel of a frame is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && frame_last;
    end
  end

  assign frame_done = frame_done_q;
`else
  logic unused_frame_last;
  assign unused_frame_last = frame_last;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// tb/tb_line_window_3x3.sv - self-checking bench for line_window_3x3 at IMG_W=IMG_H=4
module tb_line_window_3x3;

  localparam int DATA_W = 32;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int NPIX   = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_window_3x3_if #(.DATA_W(DATA_W)) bus ();

`ifdef LINE_WINDOW_FRAME_DONE_EN
  logic frame_done;
`endif

  line_window_3x3 #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LINE_WINDOW_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic                s_in_ready;
  logic                s_win_valid;
  logic [9*DATA_W-1:0] s_win_data;
  logic                s_frame_done;

  int                  m_row;
  int                  m_col;
  logic [DATA_W-1:0]   img [IMG_H][IMG_W];
  logic [9*DATA_W-1:0] exp_q [$];
  int                  n_win;

  function automatic logic [9*DATA_W-1:0] pack9(input int unsigned a0, a1, a2, a3, a4,
                                                 a5, a6, a7, a8);
    int unsigned v [9];
    logic [9*DATA_W-1:0] w;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return w;
  endfunction

  // Drive one cycle of inputs after the falling edge, sample outputs before the rising edge
  task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic wr, input logic r);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.win_ready = wr;
    #1;
    s_in_ready  = bus.in_ready;
    s_win_valid = bus.win_valid;
    s_win_data  = bus.win_data;
`ifdef LINE_WINDOW_FRAME_DONE_EN
    s_frame_done = frame_done;
`else
    s_frame_done = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    exp_q.delete();
  endtask

  // Reference: an image array per frame; every pixel at row>=2,col>=2 yields the 3x3 patch ending there.
  // At most one patch is outstanding, so the queue front is what the DUT must present.
  task automatic model_step(input logic v, input logic [DATA_W-1:0] d, input logic wr,
                            output logic acc);
    logic ev;
    logic [9*DATA_W-1:0] w;
    ev  = (exp_q.size() != 0);
    acc = v && (!ev || wr);
    if (ev && wr) begin
      void'(exp_q.pop_front());
      n_win++;
    end
    if (acc) begin
      img[m_row][m_col] = d;
      if (m_row >= 2 && m_col >= 2) begin
        w = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[(r*3+c)*DATA_W +: DATA_W] = img[m_row-2+r][m_col-2+c];
        exp_q.push_back(w);
      end
      m_col++;
      if (m_col == IMG_W) begin
        m_col = 0;
        m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
      end
    end
  endtask

  task automatic test_reset();
    logic acc;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'd55, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (s_win_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_win_valid got %b want 0", s_win_valid);
    end
    n_checks++;
    if (s_win_data !== '0) begin
      n_fail++; $display("FAIL reset_win_data got %h want 0", s_win_data);
    end
    n_checks++;
    if (s_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", s_in_ready);
    end
`ifdef LINE_WINDOW_FRAME_DONE_EN
    n_checks++;
    if (s_frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done got %b want 0", s_frame_done);
    end
`endif
    model_reset();
    model_step(1'b0, '0, 1'b0, acc);
  endtask

  task automatic test_basic();
    logic acc, v, wr, ev;
    logic [DATA_W-1:0] d;
    logic [9*DATA_W-1:0] last_w;
    int k;
    k = 0; n_win = 0; last_w = '0;
    for (int i = 0; i < NPIX + 2; i++) begin
      v = (i < NPIX); d = DATA_W'(i + 1); wr = 1'b1;
      tick(v, d, wr, 1'b0);
      ev = (exp_q.size() != 0);
      n_checks++;
      if (s_win_valid !== ev) begin
        n_fail++; $display("FAIL basic_win_valid i=%0d got %b want %b", i, s_win_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (s_win_data !== exp_q[0]) begin
          n_fail++; $display("FAIL basic_win_data i=%0d got %h want %h", i, s_win_data, exp_q[0]);
        end
      end
      if (s_win_valid && wr) begin
        k++;
        last_w = s_win_data;
        if (k == 1) begin
          n_checks++;
          if (s_win_data !== pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
            n_fail++; $display("FAIL basic_first_window got %h", s_win_data);
          end
        end
      end
      model_step(v, d, wr, acc);
    end
    n_checks++;
    if (last_w !== pack9(6, 7, 8, 10, 11, 12, 14, 15, 16)) begin
      n_fail++; $display("FAIL basic_last_window got %h", last_w);
    end
    n_checks++;
    if (k !== 4 || n_win !== 4) begin
      n_fail++; $display("FAIL basic_window_count got %0d (model %0d) want 4", k, n_win);
    end
  endtask

  task automatic test_stall();
    logic acc, v, wr, ev;
    logic [DATA_W-1:0] d;
    int p, stall_cnt, t;
    p = 0; stall_cnt = 0; n_win = 0;
    for (t = 0; t < 200 && !(p == NPIX && exp_q.size() == 0); t++) begin
      v = (p < NPIX); d = DATA_W'(p + 1);
      wr = !(p >= 11 && stall_cnt < 6);
      tick(v, d, wr, 1'b0);
      ev = (exp_q.size() != 0);
      n_checks++;
      if (s_win_valid !== ev) begin
        n_fail++; $display("FAIL stall_win_valid t=%0d got %b want %b", t, s_win_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (s_win_data !== exp_q[0]) begin
          n_fail++; $display("FAIL stall_win_data t=%0d got %h want %h", t, s_win_data, exp_q[0]);
        end
      end
      if (!wr) begin
        stall_cnt++;
        n_checks++;
        if (s_in_ready !== 1'b0 || s_win_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_hold t=%0d in_ready=%b win_valid=%b want 0/1", t, s_in_ready, s_win_valid);
        end
        n_checks++;
        if (s_win_data !== pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
          n_fail++; $display("FAIL stall_data_stable t=%0d got %h", t, s_win_data);
        end
      end
      model_step(v, d, wr, acc);
      if (acc) p++;
    end
    n_checks++;
    if (p != NPIX || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_timeout got p=%0d pending=%0d want %0d/0", p, exp_q.size(), NPIX);
    end
    n_checks++;
    if (n_win !== 4 || stall_cnt !== 6) begin
      n_fail++; $display("FAIL stall_window_count got %0d stalls %0d want 4/6", n_win, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, v, wr, ev;
    logic [DATA_W-1:0] d;
    int k;
    k = 0; n_win = 0;
    for (int i = 0; i < 2*NPIX + 2; i++) begin
      v = (i < 2*NPIX);
      d = (i < NPIX) ? DATA_W'(i + 1) : DATA_W'(101 + i - NPIX);
      wr = 1'b1;
      tick(v, d, wr, 1'b0);
      ev = (exp_q.size() != 0);
      n_checks++;
      if (s_win_valid !== ev) begin
        n_fail++; $display("FAIL b2b_win_valid i=%0d got %b want %b", i, s_win_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (s_win_data !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_win_data i=%0d got %h want %h", i, s_win_data, exp_q[0]);
        end
      end
      if (s_win_valid && wr) begin
        k++;
        if (k == 5) begin
          n_checks++;
          if (s_win_data !== pack9(101, 102, 103, 105, 106, 107, 109, 110, 111)) begin
            n_fail++; $display("FAIL b2b_frame2_first got %h", s_win_data);
          end
        end
      end
      model_step(v, d, wr, acc);
    end
    n_checks++;
    if (k !== 8) begin
      n_fail++; $display("FAIL b2b_window_count got %0d want 8", k);
    end
  endtask

  task automatic test_mid_reset();
    logic acc, v, wr, ev;
    logic [DATA_W-1:0] d;
    int k;
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, DATA_W'(i + 1), 1'b1, 1'b0);
      model_step(1'b1, DATA_W'(i + 1), 1'b1, acc);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, $urandom, 1'b1, 1'b1);
      n_checks++;
      if (s_win_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_during got %b want 0", s_win_valid);
      end
    end
    model_reset();
    k = 0; n_win = 0;
    for (int i = 0; i < NPIX + 2; i++) begin
      v = (i < NPIX); d = DATA_W'(i + 1); wr = 1'b1;
      tick(v, d, wr, 1'b0);
      ev = (exp_q.size() != 0);
      n_checks++;
      if (s_win_valid !== ev) begin
        n_fail++; $display("FAIL midrst_win_valid i=%0d got %b want %b", i, s_win_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (s_win_data !== exp_q[0]) begin
          n_fail++; $display("FAIL midrst_win_data i=%0d got %h want %h", i, s_win_data, exp_q[0]);
        end
      end
      if (s_win_valid && wr) begin
        k++;
        if (k == 1) begin
          n_checks++;
          if (i !== 11 || s_win_data !== pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
            n_fail++; $display("FAIL midrst_first_window at i=%0d got %h want i=11", i, s_win_data);
          end
        end
      end
      model_step(v, d, wr, acc);
    end
    n_checks++;
    if (k !== 4) begin
      n_fail++; $display("FAIL midrst_window_count got %0d want 4", k);
    end
  endtask

  task automatic test_random();
    logic acc, v, wr, ev;
    logic [DATA_W-1:0] d;
    int p, t;
    p = 0; n_win = 0;
    for (t = 0; t < 3000 && !(p == 3*NPIX && exp_q.size() == 0); t++) begin
      v  = (p < 3*NPIX) && ($urandom_range(0, 1) == 1);
      d  = $urandom;
      wr = ($urandom_range(0, 1) == 1);
      tick(v, d, wr, 1'b0);
      ev = (exp_q.size() != 0);
      n_checks++;
      if (s_win_valid !== ev) begin
        n_fail++; $display("FAIL rand_win_valid t=%0d got %b want %b", t, s_win_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (s_win_data !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_win_data t=%0d got %h want %h", t, s_win_data, exp_q[0]);
        end
      end
      n_checks++;
      if (s_in_ready !== (!ev || wr)) begin
        n_fail++; $display("FAIL rand_in_ready t=%0d got %b want %b", t, s_in_ready, (!ev || wr));
      end
      model_step(v, d, wr, acc);
      if (acc) p++;
    end
    n_checks++;
    if (p != 3*NPIX || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_timeout got p=%0d pending=%0d want %0d/0", p, exp_q.size(), 3*NPIX);
    end
    n_checks++;
    if (n_win !== 12) begin
      n_fail++; $display("FAIL rand_window_count got %0d want 12", n_win);
    end
  endtask

`ifdef LINE_WINDOW_FRAME_DONE_EN
  task automatic test_frame_done();
    logic acc, v, last_acc, prev_last;
    logic [DATA_W-1:0] d;
    int p, pulses, t;
    p = 0; pulses = 0; prev_last = 1'b0;
    for (t = 0; t < 500 && !(p == 2*NPIX && !prev_last); t++) begin
      v = (p < 2*NPIX) && ($urandom_range(0, 3) != 0);
      d = $urandom;
      tick(v, d, 1'b1, 1'b0);
      n_checks++;
      if (s_frame_done !== prev_last) begin
        n_fail++; $display("FAIL frame_done t=%0d got %b want %b", t, s_frame_done, prev_last);
      end
      if (s_frame_done === 1'b1) pulses++;
      last_acc = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
      model_step(v, d, 1'b1, acc);
      prev_last = acc && last_acc;
      if (acc) p++;
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_frame_done !== 1'b0 || pulses !== 2) begin
      n_fail++; $display("FAIL frame_done_count got %0d pulses (tail %b) want 2", pulses, s_frame_done);
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef LINE_WINDOW_FRAME_DONE_EN
    test_frame_done();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
